// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data single-port RAM arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DATA_W   = 32;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data, with a saturating counter that
// forces a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t winner
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                at_limit;

    assign at_limit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        winner = OWN_IF;
        if (d_req && !(if_req && at_limit)) begin
            winner = OWN_D;
        end
    end

    // Only counts while fetch is actually waiting; any gap in if_req resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (!at_limit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter for the fetch and MEM-stage data ports.
// state | meaning
// IDLE  | no access in flight; sample requests and latch the winner
// ISSUE | drive the latched access onto the RAM for one cycle
// WAIT  | RAM data valid; pulse the owner's ack with its read data
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [7:0]        if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state;
    state_t              state_nxt;
    owner_t              winner;
    owner_t              own_q;
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                grant;
    logic                d_oob;

    assign grant = (state == ST_IDLE) && (if_req || d_req);
    assign d_oob = (d_addr >> ADDR_W) != '0;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Fetch grants leave wdata_q alone so the RAM write-data bus stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= OWN_IF;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            own_q <= winner;
            if (winner == OWN_D) begin
                we_q    <= d_we;
                err_q   <= d_oob;
                addr_q  <= d_addr[ADDR_W-1:0];
                wdata_q <= d_wdata;
            end else begin
                we_q   <= 1'b0;
                err_q  <= 1'b0;
                addr_q <= ADDR_W'(if_addr);
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        if_ack   = 1'b0;
        if_rdata = '0;
        d_ack    = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        case (state)
            ST_ISSUE: begin
                mem_en = !err_q;
                mem_we = we_q && !err_q;
            end
            ST_WAIT: begin
                if (own_q == OWN_D) begin
                    d_ack = 1'b1;
                    d_err = err_q;
                    if (!we_q && !err_q) begin
                        d_rdata = mem_rdata;
                    end
                end else begin
                    if_ack   = 1'b1;
                    if_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized checks of unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;

    localparam int ADDR_W       = 10;
    localparam int STARVE_LIMIT = 4;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [7:0]        if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              d_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Power-up RAM contents, shared by the RAM macro model and the reference model.
    function automatic logic [31:0] init_word(int a);
        if (a == 5) return 32'h00A0_0093;
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    logic [31:0] ram_wr  [DEPTH];
    bit          ram_vld [DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram_wr[mem_addr]  <= mem_wdata;
                ram_vld[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_vld[mem_addr] ? ram_wr[mem_addr] : init_word(int'(mem_addr));
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one access at a time, each granted access occupies
    // three cycles (issue, ack, idle) counted from its grant edge.
    logic [31:0]       shadow [DEPTH];
    int                cyc      = 0;
    int                gnt_edge = -100;
    int                starve   = 0;
    bit                m_own_d;
    bit                m_we;
    bit                m_err;
    bit                pend_w   = 1'b0;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rexp;
    bit                exp_if_ack = 1'b0;
    bit                exp_d_ack  = 1'b0;

    task automatic model_reset();
        gnt_edge   = cyc - 100;
        starve     = 0;
        pend_w     = 1'b0;
        exp_if_ack = 1'b0;
        exp_d_ack  = 1'b0;
    endtask

    task automatic check_outputs();
        int p;
        bit e_en, e_we, e_ia, e_da;
        p    = cyc - gnt_edge;
        e_en = (p == 0) && !m_err;
        e_we = e_en && m_we;
        e_ia = (p == 1) && !m_own_d;
        e_da = (p == 1) && m_own_d;
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (e_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ack", 32'(if_ack), 32'(e_ia));
        chk("d_ack", 32'(d_ack), 32'(e_da));
        chk("if_rdata", if_rdata, e_ia ? m_rexp : 32'h0);
        chk("d_rdata", d_rdata, e_da ? m_rexp : 32'h0);
        chk("d_err", 32'(d_err), 32'(e_da && m_err));
        chk("if_stall", 32'(if_stall), 32'(if_req && !e_ia));
        chk("d_stall", 32'(d_stall), 32'(d_req && !e_da));
        exp_if_ack = e_ia;
        exp_d_ack  = e_da;
    endtask

    // Advance one clock: apply the arbitration rules to the inputs now
    // presented, then check every output just after the edge.
    task automatic tick();
        int nxt;
        bit pick_d, granted;
        nxt     = cyc + 1;
        granted = 1'b0;
        pick_d  = 1'b0;
        if (pend_w && (nxt - gnt_edge == 1)) begin
            shadow[m_addr] = m_wdata;
            pend_w         = 1'b0;
        end
        if ((nxt - gnt_edge >= 3) && (if_req || d_req)) begin
            pick_d   = d_req && !(if_req && starve == STARVE_LIMIT);
            granted  = 1'b1;
            gnt_edge = nxt;
            m_own_d  = pick_d;
            if (pick_d) begin
                m_err   = (d_addr >= 32'(DEPTH));
                m_we    = d_we;
                m_addr  = d_addr[ADDR_W-1:0];
                m_wdata = d_wdata;
                m_rexp  = (m_err || m_we) ? 32'h0 : shadow[m_addr];
                pend_w  = m_we && !m_err;
            end else begin
                m_err  = 1'b0;
                m_we   = 1'b0;
                m_addr = ADDR_W'(if_addr);
                m_rexp = shadow[m_addr];
            end
        end
        if (!if_req) starve = 0;
        else if (granted) starve = pick_d ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic new_data_txn();
        d_we    = ($urandom_range(1) == 1);
        d_wdata = $urandom;
        if ($urandom_range(7) == 0) d_addr = $urandom | 32'h0000_0400;
        else d_addr = 32'h40 + 32'($urandom_range(15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c0, d_ack_at, if_en_at, if_ack_at, n_acks;
        logic [9:0] order;

        for (int a = 0; a < DEPTH; a++) shadow[a] = init_word(a);
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state: outputs zero, stalls follow requests
        if_req = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_ack", 32'(if_ack), 32'h0);
        chk("rst_d_ack", 32'(d_ack), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        chk("rst_if_stall", 32'(if_stall), 32'h1);
        chk("rst_d_stall", 32'(d_stall), 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();

        // Lone fetch of word 5
        if_addr = 8'h05;
        if_req  = 1'b1;
        #1;
        chk("fetch_stall_c0", 32'(if_stall), 32'h1);
        tick();
        chk("fetch_en_c1", 32'(mem_en), 32'h1);
        chk("fetch_addr_c1", 32'(mem_addr), 32'h5);
        tick();
        chk("fetch_ack_c2", 32'(if_ack), 32'h1);
        chk("fetch_rdata_c2", if_rdata, 32'h00A0_0093);
        if_req = 1'b0;
        tick();
        tick();

        // Data write then read-back at 0x40
        d_addr  = 32'h40;
        d_wdata = 32'hDEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        tick();
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        tick();
        d_req = 1'b0;
        tick();
        d_we  = 1'b0;
        d_req = 1'b1;
        tick();
        tick();
        chk("rd_ack", 32'(d_ack), 32'h1);
        chk("rd_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(d_err), 32'h0);
        d_req = 1'b0;
        tick();
        tick();

        // Simultaneous requests: data first, fetch served from cycle 3
        if_addr  = 8'h07;
        if_req   = 1'b1;
        d_addr   = 32'h41;
        d_we     = 1'b0;
        d_req    = 1'b1;
        c0       = cyc;
        d_ack_at = -1;
        if_en_at = -1;
        if_ack_at = -1;
        for (int i = 0; i < 10 && if_ack_at < 0; i++) begin
            tick();
            if (d_ack) begin d_ack_at = cyc - c0; d_req = 1'b0; end
            if (mem_en && d_ack_at >= 0 && if_en_at < 0) if_en_at = cyc - c0;
            if (if_ack) begin if_ack_at = cyc - c0; if_req = 1'b0; end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("both_d_ack_cycle", 32'(d_ack_at), 32'd2);
        chk("both_if_en_cycle", 32'(if_en_at), 32'd4);
        chk("both_if_ack_cycle", 32'(if_ack_at), 32'd5);
        tick();
        tick();

        // Out-of-range data read
        d_addr = 32'h0000_0400;
        d_we   = 1'b0;
        d_req  = 1'b1;
        tick();
        chk("oob_no_en", 32'(mem_en), 32'h0);
        tick();
        chk("oob_ack", 32'(d_ack), 32'h1);
        chk("oob_err", 32'(d_err), 32'h1);
        chk("oob_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        tick();
        tick();

        // Starvation: both held, expect DDDDF twice
        if_addr = 8'h09;
        if_req  = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h40 + 32'($urandom_range(15));
        d_req   = 1'b1;
        order   = '0;
        n_acks  = 0;
        for (int i = 0; i < 60 && n_acks < 10; i++) begin
            tick();
            if (d_ack) begin
                order  = {order[8:0], 1'b0};
                n_acks++;
                d_addr = 32'h40 + 32'($urandom_range(15));
            end
            if (if_ack) begin
                order   = {order[8:0], 1'b1};
                n_acks++;
                if_addr = 8'($urandom);
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("starve_ack_count", 32'(n_acks), 32'd10);
        chk("starve_order", 32'(order), 32'h021);
        tick();
        tick();
        tick();

        // Reset during the ISSUE cycle of a data write
        d_addr  = 32'h40;
        d_wdata = 32'h1234_5678;
        d_we    = 1'b1;
        d_req   = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'h0);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst_d_ack", 32'(d_ack), 32'h0);
        chk("midrst_d_stall", 32'(d_stall), 32'h1);
        model_reset();
        d_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        d_we  = 1'b0;
        d_req = 1'b1;
        tick();
        tick();
        chk("midrst_write_dropped", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (if_req && exp_if_ack) begin
                if_req  = ($urandom_range(1) == 1);
                if_addr = 8'($urandom);
            end else if (!if_req && $urandom_range(3) == 0) begin
                if_req  = 1'b1;
                if_addr = 8'($urandom);
            end
            if (d_req && exp_d_ack) begin
                d_req = ($urandom_range(1) == 1);
                new_data_txn();
            end else if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1;
                new_data_txn();
            end
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
